serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder; the sequential successor to the combinational half_adder.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, using a single full-adder cell and a carry register.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between datapath stages that trade throughput for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_valid  input  1  producer has operands on a, b, cin.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- out_valid  output  1  sum and carry hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- carry  output  1  carry-out, bit WIDTH of a + b + cin.
- busy  output  1  high while state is RUN.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE; operand shift registers, sum register, carry register and bit counter cleared to 0.
  - out_valid = 0, busy = 0, sum = 0, carry = 0.
  - in_ready is forced to 0 while rst_n is low.
- Bit counter width is $clog2(WIDTH+1), so WIDTH = 1 is legal.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready: latch a and b into shift registers, carry_reg = cin, counter = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready = 0, busy = 1; in_valid, a, b and cin are ignored.
  - Each edge: s = a_sr[0] ^ b_sr[0] ^ carry_reg; carry_reg = majority(a_sr[0], b_sr[0], carry_reg); s shifts into sum_sr[WIDTH-1] while sum_sr shifts right; a_sr and b_sr shift right; counter increments.
  - On the edge that processes bit WIDTH-1: go to DONE.
- DONE:
  - out_valid = 1; sum = sum_sr and carry = carry_reg, held stable until the handshake.
  - On an edge with out_valid && out_ready: out_valid goes 0, state returns to IDLE.
  - sum and carry keep their last values after the handshake until the next result or reset.
- Latency: operands accepted at edge k give out_valid = 1 after edge k+WIDTH.
- Throughput: minimum spacing between accept edges is WIDTH+2. No overlap of a new accept with DONE.
- Backpressure: out_ready low in DONE holds the state indefinitely; sum, carry and out_valid must not change.
- Reset mid-operation (RUN or DONE): aborts the operation. All registers clear at that edge and no partial result is ever presented. The next operation after reset must be correct.
- Overflow: all-ones + all-ones + 1 gives sum = all-ones, carry = 1. The carry wraps into the carry output only, never back into sum.
- WIDTH = 1: single RUN cycle; with cin = 0 the block must reproduce the half-adder truth table.
- Outputs are registered or decoded from state only. No combinational path from any input to any output, except the rst_n gating of in_ready.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0 -> out_valid rises exactly 8 edges after accept; sum=0x00, carry=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry=1. Then a=100, b=27, cin=0 -> sum=127, carry=0.
- WIDTH=8, a=0x3C, b=0x0F, with out_ready held 0 for 5 cycles in DONE -> sum=0x4B, carry=0, both stable; in_ready=0 throughout; handshake on the first out_ready=1 edge; in_ready=1 on the following cycle.
- WIDTH=8, drive in_valid with new operands during RUN -> they are ignored and the original result is delivered. Measured accept-to-accept spacing with out_ready tied 1 is 10 edges.
- WIDTH=8, pull rst_n low for one edge at RUN bit 3 -> out_valid=0, busy=0, sum=0 after that edge. A subsequent 0x12+0x34 gives sum=0x46, carry=0.
- WIDTH=1 with cin=0, all four a/b combos -> sum/carry = 0/0, 1/0, 1/0, 0/1 (half-adder equivalence). WIDTH=2 exhaustive sweep of a, b and cin -> {carry, sum} == a+b+cin in every case.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell, carry register, valid/ready in and out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] sum_q;
  logic             carry_reg;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             last_bit;

  assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry_reg;
  assign bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_reg) | (b_sr[0] & carry_reg);
  assign in_ready = rst_n && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == LAST);

  generate
    if (WIDTH == 1) begin : g_one
      assign sum_shift = bit_s;
    end else begin : g_wide
      assign sum_shift = {bit_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Result is captured into separate output registers so sum/carry hold
  // their last value while the next operation is being shifted through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      sum_q     <= '0;
      carry_reg <= 1'b0;
      carry_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr      <= a;
            b_sr      <= b;
            carry_reg <= cin;
            cnt       <= '0;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          sum_sr    <= sum_shift;
          carry_reg <= bit_c;
          cnt       <= cnt + CW'(1);
          if (last_bit) begin
            sum_q   <= sum_shift;
            carry_q <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 8, 1 and 2.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 0, ir8, ci8 = 0, ov8, ordy8 = 1, c8, bz8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic       iv1 = 0, ir1, ci1 = 0, ov1, ordy1 = 1, c1, bz1;
  logic       a1 = 0, b1 = 0, s1;
  logic       iv2 = 0, ir2, ci2 = 0, ov2, ordy2 = 1, c2, bz2;
  logic [1:0] a2 = 0, b2 = 0, s2;

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(ci8), .out_valid(ov8), .out_ready(ordy8), .sum(s8), .carry(c8), .busy(bz8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(ordy1), .sum(s1), .carry(c1), .busy(bz1));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .cin(ci2), .out_valid(ov2), .out_ready(ordy2), .sum(s2), .carry(c2), .busy(bz2));

  typedef struct { logic [7:0] sum; logic carry; } res_t;
  typedef struct { int inst; logic [7:0] a; logic [7:0] b; logic cin; logic [7:0] sum; logic carry; } vec_t;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int inst, input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    case (inst)
      0: begin iv8 = v; a8 = av; b8 = bv; ci8 = cv; end
      1: begin iv1 = v; a1 = av[0]; b1 = bv[0]; ci1 = cv; end
      default: begin iv2 = v; a2 = av[1:0]; b2 = bv[1:0]; ci2 = cv; end
    endcase
  endtask

  function automatic logic ready_of(input int inst);
    case (inst)
      0: return ir8;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic int qsize(input int inst);
    case (inst)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int inst, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input bit push, input logic [7:0] es, input logic ec);
    bit done = 0;
    bit rd;
    int n = 0;
    res_t r;
    set_in(inst, 1'b1, av, bv, cv);
    while (!done && n < 50) begin
      @(negedge clk);
      rd = ready_of(inst);
      @(posedge clk);
      if (rd) done = 1;
      n++;
    end
    if (!done) fail_now("accept");
    else if (push) begin
      r.sum = es;
      r.carry = ec;
      case (inst)
        0: q0.push_back(r);
        1: q1.push_back(r);
        default: q2.push_back(r);
      endcase
    end
    #1;
    set_in(inst, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic drain(input int inst);
    int n = 0;
    while (qsize(inst) > 0 && n < 50) begin
      tick();
      n++;
    end
    if (qsize(inst) > 0) fail_now("drain");
    tick();
  endtask

  always @(negedge clk) begin
    res_t r;
    if (rst_n && ov8 && ordy8) begin
      if (q0.size() == 0) chk("unexpected_result8", 32'd1, 32'd0);
      else begin
        r = q0.pop_front();
        chk("sum8", 32'(s8), 32'(r.sum));
        chk("carry8", 32'(c8), 32'(r.carry));
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (rst_n && ov1 && ordy1) begin
      if (q1.size() == 0) chk("unexpected_result1", 32'd1, 32'd0);
      else begin
        r = q1.pop_front();
        chk("sum1", 32'(s1), 32'(r.sum));
        chk("carry1", 32'(c1), 32'(r.carry));
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (rst_n && ov2 && ordy2) begin
      if (q2.size() == 0) chk("unexpected_result2", 32'd1, 32'd0);
      else begin
        r = q2.pop_front();
        chk("sum2", 32'(s2), 32'(r.sum));
        chk("carry2", 32'(c2), 32'(r.carry));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int lat;
    int n;
    int cyc;
    int acc[2];
    bit seen;
    logic [3:0] tot;
    res_t r;

    vecs[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{0, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0};
    vecs[3] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{0, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[8] = '{1, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[9] = '{1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1};

    // Reset: in_ready gated low while rst_n is low, registers clear.
    @(negedge clk);
    chk("in_ready_in_reset", 32'(ir8), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_busy", 32'(bz8), 32'd0);
    chk("rst_sum", 32'(s8), 32'd0);
    chk("rst_carry", 32'(c8), 32'd0);
    chk("in_ready_in_reset2", 32'({ir8, ir1, ir2}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", 32'({ir8, ir1, ir2}), 32'h7);
    tick();

    // Latency: out_valid first seen after edge accept+8.
    send(0, 8'h00, 8'h00, 1'b0, 1, 8'h00, 1'b0);
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1) chk("busy_in_run", 32'(bz8), 32'd1);
      if (ov8) begin
        lat = j;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd8);
    drain(0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].cin, 1, vecs[i].sum, vecs[i].carry);
      drain(vecs[i].inst);
    end

    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      tot = 4'(vv[1:0]) + 4'(vv[3:2]) + 4'(vv[4]);
      send(2, {6'd0, vv[1:0]}, {6'd0, vv[3:2]}, vv[4], 1, {6'd0, tot[1:0]}, tot[2]);
      drain(2);
    end

    // Backpressure: result held stable for 5 cycles.
    ordy8 = 1'b0;
    send(0, 8'h3C, 8'h0F, 1'b0, 1, 8'h4B, 1'b0);
    n = 0;
    while (!ov8 && n < 20) begin
      tick();
      n++;
    end
    if (!ov8) fail_now("bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov8), 32'd1);
      chk("bp_sum", 32'(s8), 32'h4B);
      chk("bp_carry", 32'(c8), 32'd0);
      chk("bp_in_ready", 32'(ir8), 32'd0);
      tick();
    end
    ordy8 = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_valid_after", 32'(ov8), 32'd0);
    chk("bp_ready_after", 32'(ir8), 32'd1);
    chk("bp_sum_kept", 32'(s8), 32'h4B);
    tick();

    // New operands during RUN are ignored.
    send(0, 8'h11, 8'h22, 1'b0, 1, 8'h33, 1'b0);
    set_in(0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    repeat (4) tick();
    chk("run_in_ready", 32'(ir8), 32'd0);
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drain(0);

    // Accept-to-accept spacing with in_valid held and out_ready high.
    set_in(0, 1'b1, 8'h01, 8'h02, 1'b0);
    cyc = 0;
    n = 0;
    while (n < 2 && cyc < 60) begin
      @(negedge clk);
      if (ir8) begin
        acc[n] = cyc;
        n++;
        r.sum = 8'h03;
        r.carry = 1'b0;
        q0.push_back(r);
      end
      @(posedge clk);
      cyc++;
    end
    #1 set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    if (n < 2) fail_now("spacing");
    else chk("spacing", 32'(acc[1] - acc[0]), 32'd10);
    drain(0);

    // Reset at RUN bit 3 aborts with no partial result.
    send(0, 8'h77, 8'h11, 1'b0, 0, 8'h00, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(ov8), 32'd0);
    chk("abort_busy", 32'(bz8), 32'd0);
    chk("abort_sum", 32'(s8), 32'd0);
    chk("abort_carry", 32'(c8), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= ov8;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    tick();
    send(0, 8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
